rx_deframer: RTL

Post-decoder framing stage that sits directly downstream of the receiver top level. It takes the serial bit streams from the SIGNAL decoder (tail-biting convolutional) and the payload decoder (LDPC) and parses the 24-bit SIGNAL header. It then packs exactly LENGTH payload bytes, LSB first, into a byte FIFO with a valid/ready interface toward the MAC. Decoder padding bits are discarded, and header and overflow errors are flagged.

---
 rtl/rx_deframer.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/rx_deframer.sv
// Post-decoder deframer: parses the 24-bit SIGNAL header and packs LENGTH payload
// bytes (LSB first) into a byte FIFO with a valid/ready interface toward the MAC.
module rx_deframer #(
    parameter int FIFO_DEPTH = 16,
    parameter int MAX_LEN    = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        di_signal,
    input  logic        di_signal_vld,
    input  logic        di_payload,
    input  logic        di_payload_vld,
    output logic [3:0]  hdr_rate,
    output logic [11:0] hdr_len,
    output logic        hdr_vld,
    output logic        hdr_err,
    output logic [7:0]  do_byte,
    output logic        do_vld,
    output logic        do_last,
    input  logic        do_rdy,
    output logic        frame_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [31:0] MAX_LEN_U = MAX_LEN;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SIG,
        S_CHECK,
        S_PLD,
        S_DRAIN
    } state_t;

    state_t       state_q;
    logic [22:0]  sig_q;
    logic [4:0]   sig_cnt_q;
    logic [6:0]   pay_q;
    logic [2:0]   pay_cnt_q;
    logic [11:0]  byte_cnt_q;
    logic [3:0]   hdr_rate_q;
    logic [11:0]  hdr_len_q;
    logic         hdr_vld_q;
    logic         hdr_err_q;
    logic         wr_en_q;
    logic [8:0]   wr_data_q;
    logic         frame_err_q;

    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic [8:0]   mem [FIFO_DEPTH];

    // Only 23 header bits are stored; the 24th is taken straight from the input
    // so the header decision is registered in the same edge that receives it.
    logic [23:0]  sig_shift;
    logic [7:0]   pay_shift;
    logic [11:0]  len_field;
    logic         parity_ok;
    logic         tail_ok;
    logic         len_ok;
    logic         hdr_good;
    logic         reserved_unused;

    assign sig_shift       = {di_signal, sig_q};
    assign pay_shift       = {di_payload, pay_q};
    assign len_field       = sig_shift[16:5];
    assign parity_ok       = ~(^sig_shift[17:0]);
    assign tail_ok         = (sig_shift[23:18] == 6'd0);
    assign len_ok          = ({20'd0, len_field} <= MAX_LEN_U);
    assign hdr_good        = parity_ok & tail_ok & len_ok;
    assign reserved_unused = sig_shift[4];

    logic       full;
    logic       empty;
    logic       rd_en;
    logic       wr_ok;
    logic       overflow;
    logic [8:0] rd_word;

    assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty    = (wr_ptr_q == rd_ptr_q);
    assign rd_en    = ~empty & do_rdy;
    // A read in the same cycle frees the slot, so a write into a full FIFO still lands.
    assign wr_ok    = wr_en_q & (~full | rd_en);
    assign overflow = wr_en_q & full & ~rd_en;
    assign rd_word  = mem[rd_ptr_q[AW-1:0]];

    assign wr_ptr_d = wr_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = rd_en ? rd_ptr_q + 1'b1 : rd_ptr_q;

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // in this block sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sig_q       <= '0;
            sig_cnt_q   <= '0;
            pay_q       <= '0;
            pay_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            hdr_rate_q  <= '0;
            hdr_len_q   <= '0;
            hdr_vld_q   <= 1'b0;
            hdr_err_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            hdr_vld_q   <= 1'b0;
            hdr_err_q   <= 1'b0;
            wr_en_q     <= 1'b0;
            frame_err_q <= overflow;

            case (state_q)
                S_IDLE: begin
                    if (di_signal_vld) begin
                        sig_q     <= sig_shift[23:1];
                        sig_cnt_q <= 5'd1;
                        state_q   <= S_SIG;
                    end
                end

                S_SIG: begin
                    if (di_signal_vld) begin
                        sig_q     <= sig_shift[23:1];
                        sig_cnt_q <= sig_cnt_q + 5'd1;
                        if (sig_cnt_q == 5'd23) begin
                            state_q <= S_CHECK;
                            if (hdr_good) begin
                                hdr_vld_q  <= 1'b1;
                                hdr_rate_q <= sig_shift[3:0];
                                hdr_len_q  <= len_field;
                                byte_cnt_q <= len_field;
                            end else begin
                                hdr_err_q  <= 1'b1;
                            end
                        end
                    end
                end

                S_CHECK: begin
                    pay_cnt_q <= '0;
                    state_q   <= (hdr_vld_q && byte_cnt_q != 12'd0) ? S_PLD : S_DRAIN;
                end

                S_PLD: begin
                    if (di_signal_vld) begin
                        frame_err_q <= 1'b1;
                        sig_q       <= sig_shift[23:1];
                        sig_cnt_q   <= 5'd1;
                        state_q     <= S_SIG;
                    end else if (di_payload_vld) begin
                        pay_q     <= pay_shift[7:1];
                        pay_cnt_q <= pay_cnt_q + 3'd1;
                        if (pay_cnt_q == 3'd7) begin
                            wr_en_q    <= 1'b1;
                            wr_data_q  <= {(byte_cnt_q == 12'd1), pay_shift};
                            byte_cnt_q <= byte_cnt_q - 12'd1;
                            if (byte_cnt_q == 12'd1) begin
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                end

                S_DRAIN: begin
                    if (di_signal_vld) begin
                        sig_q     <= sig_shift[23:1];
                        sig_cnt_q <= 5'd1;
                        state_q   <= S_SIG;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: the storage array has no reset; emptiness is tracked by the pointers and
    // the read data is masked to zero while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (wr_ok) begin
            mem[wr_ptr_q[AW-1:0]] <= wr_data_q;
        end
    end

    assign hdr_rate  = hdr_rate_q;
    assign hdr_len   = hdr_len_q;
    assign hdr_vld   = hdr_vld_q;
    assign hdr_err   = hdr_err_q;
    assign do_vld    = ~empty;
    assign do_byte   = empty ? 8'd0 : rd_word[7:0];
    assign do_last   = empty ? 1'b0 : rd_word[8];
    assign frame_err = frame_err_q;

endmodule
